dtw_core_feeder: RTL and testbench

Upstream sequencer for the DTW core datapath.
- Collects one squiggle of SQG_SIZE samples from a valid/ready stream.
- Clears the core, then streams the squiggle and a reference read from a synchronous memory into the core with the exact per-cycle timing the core expects.
- Waits for the core's done flag and captures min value and position.
- Hands the result downstream over a valid/ready handshake.

---
 rtl/dtw_core_feeder.sv | 187 ++++++++++++++++++
 tb/tb_dtw_core_feeder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dtw_core_feeder.sv
// dtw_core_feeder: upstream sequencer for the DTW core datapath.
// Collects one squiggle, clears the core, streams squiggle and reference
// into it cycle by cycle, waits for done, then offers min value and
// position over a valid/ready handshake.
// Ports: clk/rst (sync, active-high); start/ref_base/ref_len command;
// sqg_* sample stream in; ref_en/ref_addr/ref_data sync memory port;
// core_* drive and observe the DTW core; res_* result out; busy.
// Optional: `define DTW_FEEDER_PERF_EN adds run_cycles/stall_cycles.
module dtw_core_feeder #(
    parameter int WIDTH    = 16,
    parameter int SQG_SIZE = 250,
    parameter int REF_AW   = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [REF_AW-1:0] ref_base,
    input  logic [31:0]       ref_len,
    input  logic [WIDTH-1:0]  sqg_data,
    input  logic              sqg_valid,
    output logic              sqg_ready,
    output logic              ref_en,
    output logic [REF_AW-1:0] ref_addr,
    input  logic [WIDTH-1:0]  ref_data,
    output logic              core_rst,
    output logic              core_running,
    output logic [WIDTH-1:0]  core_squiggle,
    output logic [WIDTH-1:0]  core_rword,
    output logic [31:0]       core_ref_len,
    input  logic [WIDTH-1:0]  core_minval,
    input  logic [31:0]       core_position,
    input  logic              core_done,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [WIDTH-1:0]  res_minval,
    output logic [31:0]       res_position,
    output logic              busy
`ifdef DTW_FEEDER_PERF_EN
    ,
    output logic [31:0]       run_cycles,
    output logic [31:0]       stall_cycles
`endif
);

    localparam int IW = (SQG_SIZE > 1) ? $clog2(SQG_SIZE) : 1;
    localparam logic [IW-1:0] LAST = IW'(SQG_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE, CLR, LOAD, RUN, DRAIN, RESULT
    } state_t;

    state_t state_q, state_d;

    logic [REF_AW-1:0] base_q;
    logic [REF_AW-1:0] addr_q;
    logic [31:0]       len_q;
    logic [31:0]       r_q;
    logic [IW-1:0]     n_q;
    logic [IW-1:0]     sq_idx;
    logic              d_q;
    logic [WIDTH-1:0]  sqg_buf [SQG_SIZE];

    logic accept_start;
    logic load_xfer;
    logic load_last;
    logic drain_last;
    logic in_run;

    assign accept_start = (state_q == IDLE) && start;
    assign load_xfer    = (state_q == LOAD) && sqg_valid;
    assign load_last    = load_xfer && (n_q == LAST);
    assign drain_last   = (state_q == DRAIN) && d_q;
    assign in_run       = (state_q == RUN);
    assign sq_idx       = r_q[IW-1:0] - 1'b1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)      state_d = CLR;
            CLR:                     state_d = LOAD;
            LOAD:    if (load_last)  state_d = RUN;
            RUN:     if (core_done)  state_d = DRAIN;
            DRAIN:   if (d_q)        state_d = RESULT;
            RESULT:  if (res_ready)  state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        sqg_ready     = (state_q == LOAD);
        core_rst      = rst || (state_q == CLR);
        core_running  = in_run && !core_done;
        res_valid     = (state_q == RESULT);
        busy          = (state_q != IDLE);
        core_ref_len  = '0;
        core_squiggle = '0;
        core_rword    = '0;
        ref_en        = in_run && (r_q < len_q);
        // Address holds its last issued value once reads stop
        ref_addr      = addr_q;
        if (ref_en)
            ref_addr = base_q + r_q[REF_AW-1:0];
        if (state_q != IDLE)
            core_ref_len = len_q + 32'(SQG_SIZE);
        if (in_run) begin
            core_rword = '1;
            if (r_q != 0 && r_q <= 32'(SQG_SIZE))
                core_squiggle = sqg_buf[sq_idx];
            // Memory data lags ref_en by one cycle
            if (r_q != 0 && r_q <= len_q)
                core_rword = ref_data;
        end
    end

    // Sample buffer: overwritten on each load, no reset needed
    always_ff @(posedge clk) begin
        if (load_xfer)
            sqg_buf[n_q] <= sqg_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q       <= '0;
            len_q        <= '0;
            addr_q       <= '0;
            r_q          <= '0;
            n_q          <= '0;
            d_q          <= 1'b0;
            res_minval   <= '0;
            res_position <= '0;
        end else begin
            if (accept_start) begin
                base_q <= ref_base;
                len_q  <= ref_len;
            end
            if (state_q == CLR)
                n_q <= '0;
            else if (load_xfer)
                n_q <= n_q + 1'b1;
            if (state_q == LOAD)
                r_q <= '0;
            else if (in_run && r_q != '1)
                r_q <= r_q + 32'd1;
            if (in_run)
                d_q <= 1'b0;
            else if (state_q == DRAIN)
                d_q <= 1'b1;
            if (ref_en)
                addr_q <= ref_addr;
            if (drain_last) begin
                res_minval   <= core_minval;
                res_position <= core_position;
            end
        end
    end

`ifdef DTW_FEEDER_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q      <= '0;
            run_cycles   <= '0;
            stall_cycles <= '0;
        end else begin
            if (accept_start)
                stall_q <= '0;
            else if (state_q == LOAD && !sqg_valid)
                stall_q <= stall_q + 32'd1;
            // r_q is frozen after RUN and equals its cycle count
            if (drain_last) begin
                run_cycles   <= r_q;
                stall_cycles <= stall_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dtw_core_feeder.sv
// tb_dtw_core_feeder: directed self-checking bench for dtw_core_feeder
// with SQG_SIZE=4, a behavioural sync memory and a behavioural core.
module tb_dtw_core_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [19:0] ref_base = '0;
    logic [31:0] ref_len = '0;
    logic [15:0] sqg_data = '0;
    logic        sqg_valid = 1'b0;
    logic        sqg_ready;
    logic        ref_en;
    logic [19:0] ref_addr;
    logic [15:0] ref_data = '0;
    logic        core_rst;
    logic        core_running;
    logic [15:0] core_squiggle;
    logic [15:0] core_rword;
    logic [31:0] core_ref_len;
    logic [15:0] core_minval = '0;
    logic [31:0] core_position = '0;
    logic        core_done;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_minval;
    logic [31:0] res_position;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int done_after = 10;
    int cnt = 0;
    logic [19:0] last_addr = '0;

    always #5 clk = ~clk;

    dtw_core_feeder #(.WIDTH(16), .SQG_SIZE(4), .REF_AW(20)) dut (
        .clk(clk), .rst(rst), .start(start),
        .ref_base(ref_base), .ref_len(ref_len),
        .sqg_data(sqg_data), .sqg_valid(sqg_valid), .sqg_ready(sqg_ready),
        .ref_en(ref_en), .ref_addr(ref_addr), .ref_data(ref_data),
        .core_rst(core_rst), .core_running(core_running),
        .core_squiggle(core_squiggle), .core_rword(core_rword),
        .core_ref_len(core_ref_len), .core_minval(core_minval),
        .core_position(core_position), .core_done(core_done),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_minval(res_minval), .res_position(res_position),
        .busy(busy)
    );

    // Memory: word = 0x1000 + low address bits, one cycle latency
    always @(posedge clk)
        if (ref_en) ref_data <= 16'h1000 + ref_addr[15:0];

    // Core: counts enabled cycles, done once done_after is reached
    always @(posedge clk)
        if (core_rst) cnt <= 0;
        else if (core_running) cnt <= cnt + 1;
    assign core_done = (cnt >= done_after);

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [19:0] b, input logic [31:0] l);
        start = 1'b1;
        ref_base = b;
        ref_len = l;
        step();
        start = 1'b0;
        ref_base = 20'hABCDE;
        ref_len = 32'd99;
        chk("clr core_rst", core_rst, 1'b1);
        chk("clr busy", busy, 1'b1);
        chk("clr sqg_ready", sqg_ready, 1'b0);
        step();
    endtask

    task automatic load(input logic [63:0] sq, input logic [15:0] pat,
                        input bit poke);
        int idx = 0;
        for (int c = 0; c < 16 && idx < 4; c++) begin
            chk($sformatf("load ready c=%0d", c), sqg_ready, 1'b1);
            chk($sformatf("load run c=%0d", c), core_running, 1'b0);
            sqg_valid = pat[c];
            sqg_data = pat[c] ? sq[16*idx +: 16] : 16'hBAD0;
            start = poke && (c == 1);
            step();
            if (pat[c]) idx++;
        end
        sqg_valid = 1'b0;
        start = 1'b0;
        chk("load done ready", sqg_ready, 1'b0);
    endtask

    task automatic run_phase(input logic [19:0] b, input logic [31:0] l,
                             input logic [63:0] sq, input int dn,
                             input int stop_at);
        logic [19:0] ea;
        logic [15:0] ew;
        logic [15:0] es;
        for (int r = 0; r <= dn; r++) begin
            ea = (r < l) ? b + 20'(r) : last_addr;
            es = (r >= 1 && r <= 4) ? sq[16*(r-1) +: 16] : 16'h0;
            ew = 16'hFFFF;
            if (r >= 1 && r <= l)
                ew = 16'h1000 + 16'(b + 20'(r - 1));
            chk($sformatf("running r=%0d", r), core_running, r < dn);
            chk($sformatf("ref_en r=%0d", r), ref_en, r < l);
            chk($sformatf("ref_addr r=%0d", r), ref_addr, ea);
            chk($sformatf("squiggle r=%0d", r), core_squiggle, es);
            chk($sformatf("rword r=%0d", r), core_rword, ew);
            chk($sformatf("ref_len r=%0d", r), core_ref_len, l + 4);
            if (r < l) last_addr = ea;
            if (r == stop_at) return;
            step();
        end
    endtask

    task automatic finish_result(input logic [15:0] mv, input logic [31:0] ps,
                                 input int hold);
        chk("drain1 valid", res_valid, 1'b0);
        chk("drain1 running", core_running, 1'b0);
        chk("drain1 busy", busy, 1'b1);
        step();
        chk("drain2 valid", res_valid, 1'b0);
        chk("drain2 running", core_running, 1'b0);
        step();
        chk("result valid", res_valid, 1'b1);
        chk("result minval", res_minval, mv);
        chk("result position", res_position, ps);
        for (int i = 0; i < hold; i++) begin
            res_ready = 1'b0;
            start = (i == 1);
            step();
            chk($sformatf("hold valid i=%0d", i), res_valid, 1'b1);
            chk($sformatf("hold minval i=%0d", i), res_minval, mv);
            chk($sformatf("hold pos i=%0d", i), res_position, ps);
        end
        start = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("idle valid", res_valid, 1'b0);
        chk("idle busy", busy, 1'b0);
        chk("idle minval kept", res_minval, mv);
        chk("idle pos kept", res_position, ps);
        chk("idle core_ref_len", core_ref_len, 32'd0);
    endtask

    initial begin
        step();
        step();
        chk("rst core_rst", core_rst, 1'b1);
        chk("rst busy", busy, 1'b0);
        chk("rst sqg_ready", sqg_ready, 1'b0);
        chk("rst running", core_running, 1'b0);
        chk("rst ref_en", ref_en, 1'b0);
        chk("rst ref_addr", ref_addr, 20'h0);
        chk("rst res_valid", res_valid, 1'b0);
        chk("rst core_ref_len", core_ref_len, 32'd0);
        chk("rst res_minval", res_minval, 16'h0);
        rst = 1'b0;
        step();
        chk("idle core_rst", core_rst, 1'b0);

        // Main run; start poked during LOAD and RESULT
        done_after = 10;
        core_minval = 16'h0023;
        core_position = 32'd7;
        do_start(20'h100, 32'd6);
        load({16'd40, 16'd30, 16'd20, 16'd10}, 16'hFFFF, 1'b1);
        run_phase(20'h100, 32'd6, {16'd40, 16'd30, 16'd20, 16'd10}, 10, -1);
        finish_result(16'h0023, 32'd7, 5);

        // Stalled load
        done_after = 6;
        core_minval = 16'h0005;
        core_position = 32'd3;
        do_start(20'h010, 32'd2);
        load({16'd4, 16'd3, 16'd2, 16'd1}, 16'b1010_1010_1001, 1'b0);
        run_phase(20'h010, 32'd2, {16'd4, 16'd3, 16'd2, 16'd1}, 6, -1);
        finish_result(16'h0005, 32'd3, 0);

        // ref_len = 0: no reads, padding only
        done_after = 5;
        core_minval = 16'h00AA;
        core_position = 32'd1;
        do_start(20'h777, 32'd0);
        load({16'd8, 16'd7, 16'd6, 16'd5}, 16'hFFFF, 1'b0);
        run_phase(20'h777, 32'd0, {16'd8, 16'd7, 16'd6, 16'd5}, 5, -1);
        finish_result(16'h00AA, 32'd1, 1);

        // Reset mid-RUN at r=3
        done_after = 10;
        do_start(20'h300, 32'd6);
        load({16'd4, 16'd3, 16'd2, 16'd1}, 16'hFFFF, 1'b0);
        run_phase(20'h300, 32'd6, {16'd4, 16'd3, 16'd2, 16'd1}, 10, 3);
        rst = 1'b1;
        step();
        chk("mid rst busy", busy, 1'b0);
        chk("mid rst running", core_running, 1'b0);
        chk("mid rst res_valid", res_valid, 1'b0);
        chk("mid rst core_rst", core_rst, 1'b1);
        chk("mid rst sqg_ready", sqg_ready, 1'b0);
        chk("mid rst ref_addr", ref_addr, 20'h0);
        rst = 1'b0;
        last_addr = '0;
        step();

        // Clean run after reset, ref address wrapping past 2^20
        done_after = 8;
        core_minval = 16'h1234;
        core_position = 32'd42;
        do_start(20'hFFFFE, 32'd3);
        load({16'd6, 16'd7, 16'd8, 16'd9}, 16'hFFFF, 1'b0);
        run_phase(20'hFFFFE, 32'd3, {16'd6, 16'd7, 16'd8, 16'd9}, 8, -1);
        finish_result(16'h1234, 32'd42, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
